// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared widths, FSM state encodings, access-size encodings and a small
//   helper for the byte-wide memory controller.
//   No ports; imported by mem_ctrl_if and mem_ctrl.
package mem_ctrl_pkg;

    localparam int MemAddrBus = 32;
    localparam int RegBus     = 32;
    localparam int ByteBus    = 8;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    // One state register covers both the arbiter (IDLE) and the byte sequencer.
    typedef enum logic [1:0] {
        MemCtrlIdle = 2'd0,
        IfRd        = 2'd1,
        MemRd       = 2'd2,
        MemWr       = 2'd3
    } state_e;

    // mem_size_i encodings; 2'd3 is treated as a word as well.
    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    // Which side received the most recent grant.
    typedef enum logic {
        GrantIf  = 1'b0,
        GrantMem = 1'b1
    } grant_e;

    // Number of RAM byte cycles for a data access of the given size.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        logic [2:0] count;
        count = 3'd4;
        case (size)
            SizeByte:       count = 3'd1;
            SizeHalf:       count = 3'd2;
            SizeWord, 2'd3: count = 3'd4;
            default:        count = 3'd4;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
//   Bundles the I-cache refill port, the MEM-stage load/store port and the
//   8-bit synchronous RAM bus of mem_ctrl.
//   I-fetch : branch_error, if_request_i, if_addr_i -> if_data_o, if_done_o
//   MEM     : mem_request_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i
//             -> mem_rdata_o, mem_done_o
//   RAM     : ram_din_i -> ram_dout_o, ram_a_o, ram_wr_o
//   Modports: slave = the controller, master = requesters plus RAM.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                  branch_error;
    logic                  if_request_i;
    logic [MemAddrBus-1:0] if_addr_i;
    logic [ByteBus-1:0]    if_data_o;
    logic                  if_done_o;

    logic                  mem_request_i;
    logic                  mem_we_i;
    logic [1:0]            mem_size_i;
    logic [MemAddrBus-1:0] mem_addr_i;
    logic [RegBus-1:0]     mem_wdata_i;
    logic [RegBus-1:0]     mem_rdata_o;
    logic                  mem_done_o;

    logic [ByteBus-1:0]    ram_din_i;
    logic [ByteBus-1:0]    ram_dout_o;
    logic [MemAddrBus-1:0] ram_a_o;
    logic                  ram_wr_o;

    modport slave (
        input  branch_error, if_request_i, if_addr_i,
        input  mem_request_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_data_o, if_done_o, mem_rdata_o, mem_done_o,
        output ram_dout_o, ram_a_o, ram_wr_o
    );

    modport master (
        output branch_error, if_request_i, if_addr_i,
        output mem_request_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_data_o, if_done_o, mem_rdata_o, mem_done_o,
        input  ram_dout_o, ram_a_o, ram_wr_o
    );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Arbitrates the I-cache byte-fetch port and the MEM-stage load/store port
//   onto one 8-bit synchronous RAM, serialising 1/2/4-byte data accesses into
//   byte cycles. Ties alternate between the two sides.
//   Ports:
//     clk - system clock, rising edge
//     rst - synchronous, active-low reset
//     bus - mem_ctrl_if.slave (request ports, completion ports, RAM bus)
//   RAM address/data/strobe are registered; done pulses and read data are
//   decoded from the state and ram_din_i in the completion cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    state_e                r_state,      w_state_nxt;
    logic [2:0]            r_k,          w_k_nxt;
    logic [2:0]            r_n,          w_n_nxt;
    logic [RegBus-1:0]     r_wdata,      w_wdata_nxt;
    logic [RegBus-1:0]     r_rdata,      w_rdata_nxt;
    grant_e                r_last_grant, w_last_grant_nxt;
    logic [MemAddrBus-1:0] r_ram_a,      w_ram_a_nxt;
    logic [ByteBus-1:0]    r_ram_dout,   w_ram_dout_nxt;
    logic                  r_ram_wr,     w_ram_wr_nxt;

    logic                  w_if_req;
    logic                  w_grant_mem;
    logic [1:0]            w_cap_idx;
    logic [1:0]            w_next_idx;
    logic [RegBus-1:0]     w_rdata_cap;
    logic                  w_if_done;
    logic                  w_mem_done;
    logic [ByteBus-1:0]    w_if_data;
    logic [RegBus-1:0]     w_mem_rdata;

    // A fetch request is invisible while a branch is being resolved.
    assign w_if_req = bus.if_request_i & ~bus.branch_error;

    // MEM wins alone, or on a tie when IF had the previous grant.
    assign w_grant_mem = bus.mem_request_i & (~w_if_req | (r_last_grant == GrantIf));

    // Read data lags its address by one cycle, so count k lands byte k-1.
    // In the completion cycle k equals n, which selects the last byte.
    assign w_cap_idx  = r_k[1:0] - 2'd1;
    assign w_next_idx = r_k[1:0] + 2'd1;

    always_comb begin
        w_rdata_cap = r_rdata;
        w_rdata_cap[{w_cap_idx, 3'b000} +: ByteBus] = bus.ram_din_i;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_nxt      = r_state;
        w_k_nxt          = r_k;
        w_n_nxt          = r_n;
        w_wdata_nxt      = r_wdata;
        w_rdata_nxt      = r_rdata;
        w_last_grant_nxt = r_last_grant;
        w_ram_a_nxt      = r_ram_a;
        w_ram_dout_nxt   = r_ram_dout;
        w_ram_wr_nxt     = False;
        w_if_done        = False;
        w_mem_done       = False;
        w_if_data        = '0;
        w_mem_rdata      = '0;

        case (r_state)
            MemCtrlIdle: begin
                w_k_nxt = '0;
                if (w_grant_mem) begin
                    w_state_nxt      = bus.mem_we_i ? MemWr : MemRd;
                    w_n_nxt          = size_to_count(bus.mem_size_i);
                    w_wdata_nxt      = bus.mem_wdata_i;
                    w_rdata_nxt      = '0;
                    w_last_grant_nxt = GrantMem;
                    w_ram_a_nxt      = bus.mem_addr_i;
                    w_ram_dout_nxt   = bus.mem_we_i ? bus.mem_wdata_i[ByteBus-1:0] : '0;
                    w_ram_wr_nxt     = bus.mem_we_i;
                end else if (w_if_req) begin
                    w_state_nxt      = IfRd;
                    w_last_grant_nxt = GrantIf;
                    w_ram_a_nxt      = bus.if_addr_i;
                    w_ram_dout_nxt   = '0;
                end
            end

            IfRd: begin
                if (bus.branch_error) begin
                    // Abandon the fetch silently, wherever it is.
                    w_state_nxt = MemCtrlIdle;
                    w_k_nxt     = '0;
                end else if (r_k == 3'd0) begin
                    w_k_nxt = 3'd1;
                end else begin
                    w_if_done   = True;
                    w_if_data   = bus.ram_din_i;
                    w_state_nxt = MemCtrlIdle;
                    w_k_nxt     = '0;
                end
            end

            MemRd: begin
                if (r_k == r_n) begin
                    w_mem_done  = True;
                    w_mem_rdata = w_rdata_cap;
                    w_state_nxt = MemCtrlIdle;
                    w_k_nxt     = '0;
                end else begin
                    if (r_k != 3'd0) begin
                        w_rdata_nxt = w_rdata_cap;
                    end
                    if (r_k < r_n - 3'd1) begin
                        w_ram_a_nxt = r_ram_a + 32'd1;
                    end
                    w_k_nxt = r_k + 3'd1;
                end
            end

            MemWr: begin
                if (r_k == r_n) begin
                    w_mem_done  = True;
                    w_state_nxt = MemCtrlIdle;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 3'd1;
                    // After the last byte the strobe falls back to its default of 0.
                    if (r_k < r_n - 3'd1) begin
                        w_ram_a_nxt    = r_ram_a + 32'd1;
                        w_ram_wr_nxt   = True;
                        w_ram_dout_nxt = r_wdata[{w_next_idx, 3'b000} +: ByteBus];
                    end
                end
            end

            default: begin
                w_state_nxt = MemCtrlIdle;
                w_k_nxt     = '0;
            end
        endcase
    end

    // NOTE: registers take non-blocking assignments so every one of them samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= MemCtrlIdle;
            r_k          <= '0;
            r_n          <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_last_grant <= GrantIf;
            r_ram_a      <= '0;
            r_ram_dout   <= '0;
            r_ram_wr     <= False;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_n          <= w_n_nxt;
            r_wdata      <= w_wdata_nxt;
            r_rdata      <= w_rdata_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_ram_a      <= w_ram_a_nxt;
            r_ram_dout   <= w_ram_dout_nxt;
            r_ram_wr     <= w_ram_wr_nxt;
        end
    end

    assign bus.ram_a_o     = r_ram_a;
    assign bus.ram_dout_o  = r_ram_dout;
    assign bus.ram_wr_o    = r_ram_wr;
    assign bus.if_done_o   = w_if_done;
    assign bus.if_data_o   = w_if_data;
    assign bus.mem_done_o  = w_mem_done;
    assign bus.mem_rdata_o = w_mem_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
//   Self-checking bench for mem_ctrl. A byte-addressed RAM model answers the
//   RAM bus; an independent reference memory holds what the RAM should
//   contain. Directed scenarios are followed by randomized traffic.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    // RAM contents as written by the DUT, and as they should be.
    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    // Per-cycle observation of the RAM bus during one transaction (index = cycle).
    logic [31:0] rec_a    [16];
    logic        rec_wr   [16];
    logic [7:0]  rec_dout [16];

    localparam int MaxCycles = 12;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic int bytes_of(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    // Little-endian value the reference memory holds at addr (modulo 2^32).
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n);
        logic [31:0] v;
        logic [31:0] a;
        v = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v[8*i +: 8] = ref_rd(a);
        end
        return v;
    endfunction

    // Synchronous RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        bus.ram_din_i <= ram_rd(bus.ram_a_o);
        if (bus.ram_wr_o === 1'b1) ram_mem[bus.ram_a_o] = bus.ram_dout_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.branch_error  = 1'b0;
        bus.if_request_i  = 1'b0;
        bus.if_addr_i     = '0;
        bus.mem_request_i = 1'b0;
        bus.mem_we_i      = 1'b0;
        bus.mem_size_i    = '0;
        bus.mem_addr_i    = '0;
        bus.mem_wdata_i   = '0;
    endtask

    // Issue one MEM access from an idle cycle; returns at the negedge of the
    // completion cycle (lat = cycle number of mem_done_o, MaxCycles on timeout).
    task automatic mem_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        bus.mem_request_i = 1'b1;
        bus.mem_we_i      = we;
        bus.mem_size_i    = size;
        bus.mem_addr_i    = addr;
        bus.mem_wdata_i   = wdata;
        rdata = '0;
        lat   = 0;
        @(posedge clk);
        while (lat < MaxCycles) begin
            @(negedge clk);
            lat++;
            rec_a[lat]    = bus.ram_a_o;
            rec_wr[lat]   = bus.ram_wr_o;
            rec_dout[lat] = bus.ram_dout_o;
            if (bus.mem_done_o === 1'b1) begin
                rdata = bus.mem_rdata_o;
                break;
            end
        end
        bus.mem_request_i = 1'b0;
    endtask

    task automatic if_access(input logic [31:0] addr, output logic [7:0] data, output int lat);
        bus.if_request_i = 1'b1;
        bus.if_addr_i    = addr;
        data = '0;
        lat  = 0;
        @(posedge clk);
        while (lat < MaxCycles) begin
            @(negedge clk);
            lat++;
            rec_a[lat]  = bus.ram_a_o;
            rec_wr[lat] = bus.ram_wr_o;
            if (bus.if_done_o === 1'b1) begin
                data = bus.if_data_o;
                break;
            end
        end
        bus.if_request_i = 1'b0;
    endtask

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            ref_mem[a] = wdata[8*i +: 8];
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (bus.ram_wr_o !== 1'b0) begin
            n_mismatch++; $display("FAIL reset_ram_wr: got %0b want 0", bus.ram_wr_o);
        end
        n_compared++;
        if (bus.ram_a_o !== 32'h0) begin
            n_mismatch++; $display("FAIL reset_ram_a: got %h want 0", bus.ram_a_o);
        end
        n_compared++;
        if (bus.ram_dout_o !== 8'h0) begin
            n_mismatch++; $display("FAIL reset_ram_dout: got %h want 0", bus.ram_dout_o);
        end
        n_compared++;
        if (bus.mem_done_o !== 1'b0 || bus.mem_rdata_o !== 32'h0) begin
            n_mismatch++;
            $display("FAIL reset_mem_out: got done=%0b rdata=%h want 0/0", bus.mem_done_o, bus.mem_rdata_o);
        end
        n_compared++;
        if (bus.if_done_o !== 1'b0 || bus.if_data_o !== 8'h0) begin
            n_mismatch++;
            $display("FAIL reset_if_out: got done=%0b data=%h want 0/0", bus.if_done_o, bus.if_data_o);
        end
        rst = 1'b1;
        @(negedge clk);
        n_compared++;
        if (bus.ram_wr_o !== 1'b0 || bus.mem_done_o !== 1'b0 || bus.if_done_o !== 1'b0) begin
            n_mismatch++;
            $display("FAIL reset_release_idle: got wr=%0b mdone=%0b idone=%0b want 0/0/0",
                     bus.ram_wr_o, bus.mem_done_o, bus.if_done_o);
        end
    endtask

    task automatic test_word_load();
        logic [31:0] rdata;
        int          lat;
        // Place 11,22,33,44 at 0x100..0x103 through the store path.
        mem_access(1'b1, 2'd2, 32'h100, 32'h44332211, rdata, lat);
        ref_store(32'h100, 32'h44332211, 4);
        @(negedge clk);
        mem_access(1'b0, 2'd2, 32'h100, 32'h0, rdata, lat);
        n_compared++;
        if (lat != 5) begin
            n_mismatch++; $display("FAIL word_load_latency: got %0d want 5", lat);
        end
        for (int k = 0; k < 4; k++) begin
            n_compared++;
            if (rec_a[k+1] !== 32'h100 + 32'(k)) begin
                n_mismatch++;
                $display("FAIL word_load_addr%0d: got %h want %h", k, rec_a[k+1], 32'h100 + 32'(k));
            end
        end
        n_compared++;
        if (rdata !== ref_load(32'h100, 4)) begin
            n_mismatch++; $display("FAIL word_load_data: got %h want %h", rdata, ref_load(32'h100, 4));
        end
        @(negedge clk);
    endtask

    task automatic test_half_store();
        logic [31:0] rdata;
        int          lat;
        int          wr_cycles;
        mem_access(1'b1, 2'd1, 32'h200, 32'hDEADBEEF, rdata, lat);
        ref_store(32'h200, 32'hDEADBEEF, 2);
        n_compared++;
        if (lat != 3) begin
            n_mismatch++; $display("FAIL half_store_latency: got %0d want 3", lat);
        end
        n_compared++;
        if (rec_wr[1] !== 1'b1 || rec_a[1] !== 32'h200 || rec_dout[1] !== 8'hEF) begin
            n_mismatch++;
            $display("FAIL half_store_byte0: got wr=%0b a=%h d=%h want 1/00000200/ef",
                     rec_wr[1], rec_a[1], rec_dout[1]);
        end
        n_compared++;
        if (rec_wr[2] !== 1'b1 || rec_a[2] !== 32'h201 || rec_dout[2] !== 8'hBE) begin
            n_mismatch++;
            $display("FAIL half_store_byte1: got wr=%0b a=%h d=%h want 1/00000201/be",
                     rec_wr[2], rec_a[2], rec_dout[2]);
        end
        wr_cycles = 0;
        for (int c = 1; c <= lat; c++) if (rec_wr[c] === 1'b1) wr_cycles++;
        n_compared++;
        if (wr_cycles != 2) begin
            n_mismatch++; $display("FAIL half_store_wr_cycles: got %0d want 2", wr_cycles);
        end
        @(negedge clk);
        n_compared++;
        if (ram_rd(32'h202) !== ref_rd(32'h202) || ram_rd(32'h201) !== ref_rd(32'h201)) begin
            n_mismatch++;
            $display("FAIL half_store_ram: got [201]=%h [202]=%h want %h %h",
                     ram_rd(32'h201), ram_rd(32'h202), ref_rd(32'h201), ref_rd(32'h202));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rdata;
        logic [31:0] exp_a [4];
        int          lat;
        exp_a[0] = 32'hFFFFFFFE;
        exp_a[1] = 32'hFFFFFFFF;
        exp_a[2] = 32'h00000000;
        exp_a[3] = 32'h00000001;
        mem_access(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, rdata, lat);
        for (int k = 0; k < 4; k++) begin
            n_compared++;
            if (rec_a[k+1] !== exp_a[k]) begin
                n_mismatch++; $display("FAIL wrap_addr%0d: got %h want %h", k, rec_a[k+1], exp_a[k]);
            end
        end
        n_compared++;
        if (rdata !== {ref_rd(exp_a[3]), ref_rd(exp_a[2]), ref_rd(exp_a[1]), ref_rd(exp_a[0])}) begin
            n_mismatch++;
            $display("FAIL wrap_data: got %h want %h", rdata,
                     {ref_rd(exp_a[3]), ref_rd(exp_a[2]), ref_rd(exp_a[1]), ref_rd(exp_a[0])});
        end
        @(negedge clk);
    endtask

    task automatic test_branch_abort();
        logic [7:0] data;
        int         lat;
        bit         saw_done;
        bus.if_request_i = 1'b1;
        bus.if_addr_i    = 32'h40;
        @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (bus.ram_a_o !== 32'h40) begin
            n_mismatch++; $display("FAIL abort_addr_cycle: got %h want 00000040", bus.ram_a_o);
        end
        bus.branch_error = 1'b1;
        bus.if_request_i = 1'b0;
        @(negedge clk);
        n_compared++;
        if (bus.if_done_o !== 1'b0) begin
            n_mismatch++; $display("FAIL abort_no_done: got %0b want 0", bus.if_done_o);
        end
        // Controller is idle now, so this fetch is granted at the very next edge.
        bus.branch_error = 1'b0;
        if_access(32'h80, data, lat);
        n_compared++;
        if (lat != 2 || data !== ref_rd(32'h80)) begin
            n_mismatch++;
            $display("FAIL abort_refetch: got lat=%0d data=%h want 2/%h", lat, data, ref_rd(32'h80));
        end
        @(negedge clk);
        // A fetch request is ignored while branch_error is high.
        bus.if_request_i = 1'b1;
        bus.if_addr_i    = 32'hC0;
        bus.branch_error = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.if_done_o === 1'b1 || bus.ram_a_o === 32'hC0) saw_done = 1'b1;
        end
        n_compared++;
        if (saw_done) begin
            n_mismatch++; $display("FAIL branch_masks_request: got grant want none");
        end
        bus.branch_error = 1'b0;
        if_access(32'hC0, data, lat);
        n_compared++;
        if (lat != 2 || data !== ref_rd(32'hC0)) begin
            n_mismatch++;
            $display("FAIL branch_release_fetch: got lat=%0d data=%h want 2/%h", lat, data, ref_rd(32'hC0));
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int ev_cnt;
        int ev_mem [8];
        int ev_cyc [8];
        clear_inputs();
        rst = 1'b0;
        bus.mem_request_i = 1'b1;
        bus.mem_addr_i    = 32'h600;
        bus.mem_size_i    = 2'd0;
        bus.if_request_i  = 1'b1;
        bus.if_addr_i     = 32'h610;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ev_cnt = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (bus.mem_done_o === 1'b1) begin
                n_compared++;
                if (bus.mem_rdata_o !== {24'h0, ref_rd(32'h600)}) begin
                    n_mismatch++;
                    $display("FAIL contention_mem_data: got %h want %h", bus.mem_rdata_o, {24'h0, ref_rd(32'h600)});
                end
                if (ev_cnt < 8) begin ev_mem[ev_cnt] = 1; ev_cyc[ev_cnt] = c; end
                ev_cnt++;
            end
            if (bus.if_done_o === 1'b1) begin
                n_compared++;
                if (bus.if_data_o !== ref_rd(32'h610)) begin
                    n_mismatch++;
                    $display("FAIL contention_if_data: got %h want %h", bus.if_data_o, ref_rd(32'h610));
                end
                if (ev_cnt < 8) begin ev_mem[ev_cnt] = 0; ev_cyc[ev_cnt] = c; end
                ev_cnt++;
            end
        end
        clear_inputs();
        n_compared++;
        if (ev_cnt != 8) begin
            n_mismatch++; $display("FAIL contention_count: got %0d want 8", ev_cnt);
        end
        for (int i = 0; i < 8 && i < ev_cnt; i++) begin
            n_compared++;
            if (ev_mem[i] != ((i % 2 == 0) ? 1 : 0) || ev_cyc[i] != 2 + 3 * i) begin
                n_mismatch++;
                $display("FAIL contention_order%0d: got mem=%0d cycle=%0d want mem=%0d cycle=%0d",
                         i, ev_mem[i], ev_cyc[i], (i % 2 == 0) ? 1 : 0, 2 + 3 * i);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        wdata = $urandom;
        bus.mem_request_i = 1'b1;
        bus.mem_we_i      = 1'b1;
        bus.mem_size_i    = 2'd2;
        bus.mem_addr_i    = 32'h500;
        bus.mem_wdata_i   = wdata;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_compared++;
        if (bus.ram_wr_o !== 1'b1 || bus.ram_a_o !== 32'h501 || bus.ram_dout_o !== wdata[15:8]) begin
            n_mismatch++;
            $display("FAIL midstore_byte1: got wr=%0b a=%h d=%h want 1/00000501/%h",
                     bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o, wdata[15:8]);
        end
        rst = 1'b0;
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_compared++;
            if (bus.ram_wr_o !== 1'b0 || bus.mem_done_o !== 1'b0 || bus.if_done_o !== 1'b0) begin
                n_mismatch++;
                $display("FAIL midstore_reset%0d: got wr=%0b mdone=%0b idone=%0b want 0/0/0",
                         c, bus.ram_wr_o, bus.mem_done_o, bus.if_done_o);
            end
        end
        rst = 1'b1;
        // Bytes 0 and 1 were strobed before the reset edge took effect.
        ref_store(32'h500, wdata, 2);
        n_compared++;
        if (ram_rd(32'h502) !== ref_rd(32'h502)) begin
            n_mismatch++; $display("FAIL midstore_no_byte2: got %h want %h", ram_rd(32'h502), ref_rd(32'h502));
        end
        mem_access(1'b0, 2'd0, 32'h501, 32'h0, rdata, lat);
        n_compared++;
        if (lat != 2 || rdata !== {24'h0, ref_rd(32'h501)}) begin
            n_mismatch++;
            $display("FAIL midstore_reload: got lat=%0d data=%h want 2/%h", lat, rdata, {24'h0, ref_rd(32'h501)});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] a_k;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  idata;
        logic [1:0]  size;
        logic        we;
        int          lat;
        int          n;
        int          op;
        bit          bad;
        for (int t = 0; t < 40; t++) begin
            op   = int'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                : 32'h300 + 32'($urandom_range(0, 31));
            if (op == 0) begin
                if_access(addr, idata, lat);
                n_compared++;
                if (lat != 2 || idata !== ref_rd(addr) || rec_a[1] !== addr) begin
                    n_mismatch++;
                    $display("FAIL rand_if[%0d]: got lat=%0d a=%h data=%h want 2/%h/%h",
                             t, lat, rec_a[1], idata, addr, ref_rd(addr));
                end
            end else begin
                we    = (op == 2);
                size  = 2'($urandom_range(0, 3));
                wdata = $urandom;
                n     = bytes_of(size);
                mem_access(we, size, addr, wdata, rdata, lat);
                n_compared++;
                if (lat != n + 1) begin
                    n_mismatch++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, lat, n + 1);
                end
                bad = 1'b0;
                for (int k = 0; k < n; k++) begin
                    a_k = addr + 32'(k);
                    if (rec_a[k+1] !== a_k) bad = 1'b1;
                    if (we && (rec_wr[k+1] !== 1'b1 || rec_dout[k+1] !== wdata[8*k +: 8])) bad = 1'b1;
                    if (!we && rec_wr[k+1] !== 1'b0) bad = 1'b1;
                end
                if (rec_wr[n+1] !== 1'b0) bad = 1'b1;
                n_compared++;
                if (bad) begin
                    n_mismatch++;
                    $display("FAIL rand_bus[%0d]: got wrong byte sequence want we=%0b addr=%h n=%0d wdata=%h",
                             t, we, addr, n, wdata);
                end
                if (we) begin
                    ref_store(addr, wdata, n);
                end else begin
                    n_compared++;
                    if (rdata !== ref_load(addr, n)) begin
                        n_mismatch++;
                        $display("FAIL rand_load[%0d]: got %h want %h", t, rdata, ref_load(addr, n));
                    end
                end
            end
            @(negedge clk);
            n_compared++;
            if (bus.mem_done_o !== 1'b0 || bus.if_done_o !== 1'b0 || bus.ram_wr_o !== 1'b0) begin
                n_mismatch++;
                $display("FAIL rand_idle_gap[%0d]: got mdone=%0b idone=%0b wr=%0b want 0/0/0",
                         t, bus.mem_done_o, bus.if_done_o, bus.ram_wr_o);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_word_load();
        test_half_store();
        test_wrap();
        test_branch_abort();
        test_contention();
        test_reset_mid_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide memory controller and arbiter between the instruction-cache refill port and the MEM-stage load/store port. It owns the single 8-bit synchronous RAM interface and serialises 1/2/4-byte data accesses into byte cycles. It grants instruction-fetch bytes in between data accesses and applies alternating priority so neither side starves. It sits between `cache_i`/MEM stage and the RAM/IO bus.

## Interface
Parameters: none; widths come from the shared defines (`MemAddrBus` = 32, `RegBus` = 32, `ByteBus` = 8).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- branch_error  in  1  abort any in-flight instruction byte fetch
- if_request_i  in  1  I-cache wants one byte
- if_addr_i  in  32  byte address of fetch
- if_data_o  out  8  fetched byte, valid only while if_done_o=1
- if_done_o  out  1  one-cycle completion pulse
- mem_request_i  in  1  MEM-stage access request
- mem_we_i  in  1  1 = store, 0 = load
- mem_size_i  in  2  0 = byte, 1 = half, 2 or 3 = word
- mem_addr_i  in  32  base byte address
- mem_wdata_i  in  32  store data, little-endian, low bytes used
- mem_rdata_o  out  32  load data, zero-extended, valid only while mem_done_o=1
- mem_done_o  out  1  one-cycle completion pulse
- ram_din_i  in  8  RAM read data, valid the cycle after its address
- ram_dout_o  out  8  RAM write data
- ram_a_o  out  32  RAM byte address
- ram_wr_o  out  1  RAM write strobe

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter k (3 bits), byte count n = 1/2/4 from mem_size_i, latched at grant. Also latched at grant: address, data and a last_grant flag.
- In IDLE, requests are sampled at each edge.
  - Only one side requesting: that side is granted.
  - Both requesting: the side that was not granted last wins. After reset, MEM wins.
  - if_request_i is ignored in any cycle where branch_error=1.
- IF_RD: drive ram_a_o=addr. Next cycle, if_done_o=1 and if_data_o=ram_din_i. Then return to IDLE.
- MEM_RD: for k=0..n-1, drive ram_a_o=addr+k in cycle k and capture ram_din_i into byte k in cycle k+1. In cycle n, mem_done_o=1 and mem_rdata_o holds the assembled value, upper bytes 0. Then return to IDLE.
- MEM_WR: for k=0..n-1, drive ram_a_o=addr+k, ram_dout_o=wdata byte k, ram_wr_o=1. In cycle n, ram_wr_o=0 and mem_done_o=1. Then return to IDLE.
- Address arithmetic is modulo 2^32; addr+k wraps from 0xFFFFFFFF to 0.
- branch_error while in IF_RD: no if_done_o is emitted and the state is IDLE at the next edge. branch_error never affects MEM_RD or MEM_WR.
- Requests are not re-sampled while busy. Inputs other than ram_din_i are used only at grant.

## Timing
- All outputs are registered except if_data_o, if_done_o, mem_rdata_o and mem_done_o. Those are decoded from state and ram_din_i in the completion cycle.
- Reset values: all outputs 0, state IDLE, last_grant=IF so MEM wins the first tie, k=0.
- Cycle numbering: grant edge E0; cycle 1 is the first RAM address cycle.
- Latency from grant edge: IF byte 2 cycles; MEM access of n bytes n+1 cycles. The done pulse lasts exactly 1 cycle.
- A mandatory IDLE cycle follows every done cycle, so requesters can update request/addr on the done edge. Back-to-back IF bytes cost 3 cycles each.
- rst=0 at any edge: at that edge the state becomes IDLE, ram_wr_o=0 and no done pulse is emitted. A partially written store is not rolled back.
- ram_wr_o is never asserted outside MEM_WR.

## Structure
- Add to the shared defines header:
  - state encodings `MemCtrlIdle`/`IfRd`/`MemRd`/`MemWr`
  - size encodings `SizeByte`/`SizeHalf`/`SizeWord`
- Reuse the existing `True`/`False`, `RegBus`, `ByteBus` and `MemAddrBus` defines.
- Single module; no sub-module. The arbiter and byte sequencer are small enough to share one state register.

## Test plan
- Word load: mem_addr_i=0x100, size 2, RAM[0x100..0x103]=11,22,33,44 → ram_a_o steps 0x100..0x103 on cycles 1–4; mem_done_o pulses in cycle 5 with 0x44332211.
- Half store: addr 0x200, wdata 0xDEADBEEF → two write cycles with (0x200,EF) then (0x201,BE), ram_wr_o=1 for exactly 2 cycles; mem_done_o pulses in the next cycle; RAM[0x202] unchanged.
- Contention: if_request_i and mem_request_i held high from reset → MEM granted first, IF next, then alternating. Each side gets a done pulse at least every other transaction.
- Branch abort: IF fetch of 0x40 granted, branch_error=1 in the address cycle → no if_done_o; state IDLE next edge; a new fetch of 0x80 completes with RAM[0x80].
- Wrap: word load at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, and the result is assembled in that order.
- Reset mid-store: rst=0 during the 2nd byte of a word store → ram_wr_o=0 and all done outputs 0 from that edge. After release, a byte load completes normally in 2 cycles.
